// File: rtl/alu_share_arb.sv
// Round-robin sharing of one combinational ALU between NUM_REQ requesters.
// One operation in flight: accept -> EXEC (ALU evaluates) -> RESP (held until taken).
module alu_share_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*3-1:0]            req_func3,
    input  logic [NUM_REQ*7-1:0]            req_func7,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_rs1_data,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_rs2_data,
    output logic [2:0]                      alu_func3,
    output logic [6:0]                      alu_func7,
    output logic [DATA_WIDTH-1:0]           alu_rs1_data,
    output logic [DATA_WIDTH-1:0]           alu_rs2_data,
    input  logic [DATA_WIDTH-1:0]           alu_rd_data,
    input  logic                            alu_logic_data,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [ID_WIDTH-1:0]             rsp_id,
    output logic [DATA_WIDTH-1:0]           rsp_rd_data,
    output logic                            rsp_logic_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [ID_WIDTH-1:0]    last_grant_reg;
    logic [ID_WIDTH-1:0]    id_reg;
    logic [2:0]             alu_func3_reg;
    logic [6:0]             alu_func7_reg;
    logic [DATA_WIDTH-1:0]  alu_rs1_reg;
    logic [DATA_WIDTH-1:0]  alu_rs2_reg;
    logic [ID_WIDTH-1:0]    rsp_id_reg;
    logic [DATA_WIDTH-1:0]  rsp_rd_data_reg;
    logic                   rsp_logic_data_reg;

    logic [2:0]             func3_arr [NUM_REQ];
    logic [6:0]             func7_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]  rs1_arr   [NUM_REQ];
    logic [DATA_WIDTH-1:0]  rs2_arr   [NUM_REQ];

    // Candidate k is the requester at distance k+1 from the last grant, wrapped.
    logic [ID_WIDTH:0]      cand_sum  [NUM_REQ];
    logic [ID_WIDTH-1:0]    cand_idx  [NUM_REQ];

    logic                   grant_found;
    logic [ID_WIDTH-1:0]    grant_idx;
    logic                   accept_window;
    logic                   accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign func3_arr[gi] = req_func3[gi*3 +: 3];
            assign func7_arr[gi] = req_func7[gi*7 +: 7];
            assign rs1_arr[gi]   = req_rs1_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign rs2_arr[gi]   = req_rs2_data[gi*DATA_WIDTH +: DATA_WIDTH];

            assign cand_sum[gi] = {1'b0, last_grant_reg} + (ID_WIDTH+1)'(gi + 1);
            assign cand_idx[gi] = (cand_sum[gi] >= (ID_WIDTH+1)'(NUM_REQ))
                                ? ID_WIDTH'(cand_sum[gi] - (ID_WIDTH+1)'(NUM_REQ))
                                : ID_WIDTH'(cand_sum[gi]);

            assign req_ready[gi] = accept && (grant_idx == ID_WIDTH'(gi));
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest valid one wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    assign accept_window = (state_reg == IDLE) || ((state_reg == RESP) && rsp_ready);
    // Gated by rst so req_ready reads zero for the whole reset interval.
    assign accept        = !rst && accept_window && grant_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = accept ? EXEC : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ALU drive registers move only on accept so the ALU inputs stay quiet otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= ID_WIDTH'(NUM_REQ - 1);
            id_reg         <= '0;
            alu_func3_reg  <= '0;
            alu_func7_reg  <= '0;
            alu_rs1_reg    <= '0;
            alu_rs2_reg    <= '0;
        end else if (accept) begin
            last_grant_reg <= grant_idx;
            id_reg         <= grant_idx;
            alu_func3_reg  <= func3_arr[grant_idx];
            alu_func7_reg  <= func7_arr[grant_idx];
            alu_rs1_reg    <= rs1_arr[grant_idx];
            alu_rs2_reg    <= rs2_arr[grant_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id_reg         <= '0;
            rsp_rd_data_reg    <= '0;
            rsp_logic_data_reg <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_id_reg         <= id_reg;
            rsp_rd_data_reg    <= alu_rd_data;
            rsp_logic_data_reg <= alu_logic_data;
        end
    end

    assign alu_func3      = alu_func3_reg;
    assign alu_func7      = alu_func7_reg;
    assign alu_rs1_data   = alu_rs1_reg;
    assign alu_rs2_data   = alu_rs2_reg;
    assign rsp_valid      = (state_reg == RESP);
    assign rsp_id         = rsp_id_reg;
    assign rsp_rd_data    = rsp_rd_data_reg;
    assign rsp_logic_data = rsp_logic_data_reg;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a 2-requester instance for the main flows
// and a 4-requester instance for round-robin fairness; a small ALU model closes each loop.
module tb_alu_share_arb;

    logic clk;
    logic rst;

    // Instance A: NUM_REQ = 2
    logic [1:0]   a_req_valid;
    logic [1:0]   a_req_ready;
    logic [5:0]   a_req_func3;
    logic [13:0]  a_req_func7;
    logic [63:0]  a_req_rs1;
    logic [63:0]  a_req_rs2;
    logic [2:0]   a_alu_func3;
    logic [6:0]   a_alu_func7;
    logic [31:0]  a_alu_rs1;
    logic [31:0]  a_alu_rs2;
    logic [31:0]  a_alu_rd;
    logic         a_alu_logic;
    logic         a_rsp_valid;
    logic         a_rsp_ready;
    logic [0:0]   a_rsp_id;
    logic [31:0]  a_rsp_rd;
    logic         a_rsp_logic;

    // Instance B: NUM_REQ = 4
    logic [3:0]   b_req_valid;
    logic [3:0]   b_req_ready;
    logic [11:0]  b_req_func3;
    logic [27:0]  b_req_func7;
    logic [127:0] b_req_rs1;
    logic [127:0] b_req_rs2;
    logic [2:0]   b_alu_func3;
    logic [6:0]   b_alu_func7;
    logic [31:0]  b_alu_rs1;
    logic [31:0]  b_alu_rs2;
    logic [31:0]  b_alu_rd;
    logic         b_alu_logic;
    logic         b_rsp_valid;
    logic         b_rsp_ready;
    logic [1:0]   b_rsp_id;
    logic [31:0]  b_rsp_rd;
    logic         b_rsp_logic;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    alu_share_arb #(.DATA_WIDTH(32), .NUM_REQ(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_func3(a_req_func3), .req_func7(a_req_func7),
        .req_rs1_data(a_req_rs1), .req_rs2_data(a_req_rs2),
        .alu_func3(a_alu_func3), .alu_func7(a_alu_func7),
        .alu_rs1_data(a_alu_rs1), .alu_rs2_data(a_alu_rs2),
        .alu_rd_data(a_alu_rd), .alu_logic_data(a_alu_logic),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_id(a_rsp_id),
        .rsp_rd_data(a_rsp_rd), .rsp_logic_data(a_rsp_logic)
    );

    alu_share_arb #(.DATA_WIDTH(32), .NUM_REQ(4)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_func3(b_req_func3), .req_func7(b_req_func7),
        .req_rs1_data(b_req_rs1), .req_rs2_data(b_req_rs2),
        .alu_func3(b_alu_func3), .alu_func7(b_alu_func7),
        .alu_rs1_data(b_alu_rs1), .alu_rs2_data(b_alu_rs2),
        .alu_rd_data(b_alu_rd), .alu_logic_data(b_alu_logic),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
        .rsp_rd_data(b_rsp_rd), .rsp_logic_data(b_rsp_logic)
    );

    // Stand-in for the shared ALU: ADD, SUB, XOR and EQ; anything else yields 0.
    function automatic logic [32:0] alu_model(input logic [6:0] f7, input logic [2:0] f3,
                                              input logic [31:0] x, input logic [31:0] y);
        case ({f7, f3})
            {7'h00, 3'd0}: return {1'b0, x + y};
            {7'h20, 3'd0}: return {1'b0, x - y};
            {7'h00, 3'd4}: return {1'b0, x ^ y};
            {7'h40, 3'd4}: return {(x == y), 32'd0};
            default:       return 33'd0;
        endcase
    endfunction

    assign {a_alu_logic, a_alu_rd} = alu_model(a_alu_func7, a_alu_func3, a_alu_rs1, a_alu_rs2);
    assign {b_alu_logic, b_alu_rd} = alu_model(b_alu_func7, b_alu_func3, b_alu_rs1, b_alu_rs2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int i, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] r1, input logic [31:0] r2);
        a_req_func7[i*7 +: 7]  = f7;
        a_req_func3[i*3 +: 3]  = f3;
        a_req_rs1[i*32 +: 32]  = r1;
        a_req_rs2[i*32 +: 32]  = r2;
    endtask

    task automatic set_b(input int i, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] r1, input logic [31:0] r2);
        b_req_func7[i*7 +: 7]  = f7;
        b_req_func3[i*3 +: 3]  = f3;
        b_req_rs1[i*32 +: 32]  = r1;
        b_req_rs2[i*32 +: 32]  = r2;
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = '0; a_req_func3 = '0; a_req_func7 = '0; a_req_rs1 = '0; a_req_rs2 = '0;
        a_rsp_ready = 1'b1;
        b_req_valid = '0; b_req_func3 = '0; b_req_func7 = '0; b_req_rs1 = '0; b_req_rs2 = '0;
        b_rsp_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(a_req_ready), 64'd0);
        chk("rst_rsp_id",    64'(a_rsp_id),    64'd0);
        chk("rst_rsp_rd",    64'(a_rsp_rd),    64'd0);
        chk("rst_rsp_logic", 64'(a_rsp_logic), 64'd0);
        chk("rst_alu_f3",    64'(a_alu_func3), 64'd0);
        chk("rst_alu_f7",    64'(a_alu_func7), 64'd0);
        chk("rst_alu_rs1",   64'(a_alu_rs1),   64'd0);
        step();
        rst = 1'b0;

        // Single ADD on req0: 5 + 7
        set_a(0, 7'h00, 3'd0, 32'd5, 32'd7);
        a_req_valid = 2'b01;
        #1;
        chk("add_req_ready", 64'(a_req_ready), 64'h1);
        step();
        a_req_valid = 2'b00;
        #1;
        chk("add_exec_valid", 64'(a_rsp_valid), 64'd0);
        chk("add_alu_rs1",    64'(a_alu_rs1),   64'd5);
        chk("add_alu_rs2",    64'(a_alu_rs2),   64'd7);
        step();
        chk("add_rsp_valid", 64'(a_rsp_valid), 64'd1);
        chk("add_rsp_id",    64'(a_rsp_id),    64'd0);
        chk("add_rsp_rd",    64'(a_rsp_rd),    64'd12);
        step();
        chk("add_retired", 64'(a_rsp_valid), 64'd0);

        // Both valid after reset: req0 SUB 10-3, req1 EQ 9==9
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_a(0, 7'h20, 3'd0, 32'd10, 32'd3);
        set_a(1, 7'h40, 3'd4, 32'd9,  32'd9);
        a_req_valid = 2'b11;
        #1;
        chk("both_first_grant", 64'(a_req_ready), 64'h1);
        step();
        a_req_valid = 2'b10;
        #1;
        chk("both_exec_ready", 64'(a_req_ready), 64'h0);
        step();
        chk("sub_rsp_valid", 64'(a_rsp_valid), 64'd1);
        chk("sub_rsp_id",    64'(a_rsp_id),    64'd0);
        chk("sub_rsp_rd",    64'(a_rsp_rd),    64'd7);
        chk("both_second_grant", 64'(a_req_ready), 64'h2);
        step();
        a_req_valid = 2'b00;
        #1;
        chk("eq_exec_gap", 64'(a_rsp_valid), 64'd0);
        step();
        chk("eq_rsp_valid", 64'(a_rsp_valid), 64'd1);
        chk("eq_rsp_id",    64'(a_rsp_id),    64'd1);
        chk("eq_rsp_logic", 64'(a_rsp_logic), 64'd1);
        chk("eq_rsp_rd",    64'(a_rsp_rd),    64'd0);
        step();

        // Back-pressure: req0 ADD 1+2 stalls 5 cycles with req1 XOR pending
        set_a(0, 7'h00, 3'd0, 32'd1,    32'd2);
        set_a(1, 7'h00, 3'd4, 32'hF0,   32'h0F);
        a_rsp_ready = 1'b0;
        a_req_valid = 2'b11;
        #1;
        chk("bp_grant", 64'(a_req_ready), 64'h1);
        step();
        a_req_valid = 2'b10;
        step();
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", 64'(a_rsp_valid), 64'd1);
            chk("bp_rsp_rd",    64'(a_rsp_rd),    64'd3);
            chk("bp_rsp_id",    64'(a_rsp_id),    64'd0);
            chk("bp_req_ready", 64'(a_req_ready), 64'h0);
            step();
        end
        a_rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 64'(a_req_ready), 64'h2);
        step();
        a_req_valid = 2'b00;
        #1;
        chk("bp_retired", 64'(a_rsp_valid), 64'd0);
        step();
        chk("xor_rsp_id", 64'(a_rsp_id), 64'd1);
        chk("xor_rsp_rd", 64'(a_rsp_rd), 64'hFF);
        step();

        // Back-to-back: grants alternate 0,1,0,1, one response per 2 cycles
        set_a(0, 7'h00, 3'd0, 32'd1, 32'd1);
        set_a(1, 7'h00, 3'd0, 32'd2, 32'd2);
        a_req_valid = 2'b11;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("b2b_exec_gap", 64'(a_rsp_valid), 64'd0);
            step();
            chk("b2b_rsp_valid", 64'(a_rsp_valid), 64'd1);
            chk("b2b_rsp_id",    64'(a_rsp_id),    64'(i % 2));
            chk("b2b_rsp_rd",    64'(a_rsp_rd),    (i % 2 == 1) ? 64'd4 : 64'd2);
            chk("b2b_next_grant", 64'(a_req_ready), (i % 2 == 1) ? 64'h1 : 64'h2);
            step();
        end
        a_req_valid = 2'b00;
        step();
        step();
        chk("b2b_drained", 64'(a_rsp_valid), 64'd0);

        // Reset during EXEC of XOR 0xF0 ^ 0x0F
        set_a(0, 7'h00, 3'd4, 32'hF0, 32'h0F);
        a_req_valid = 2'b01;
        step();
        a_req_valid = 2'b00;
        #1;
        chk("mid_alu_rs1", 64'(a_alu_rs1),   64'hF0);
        chk("mid_alu_f3",  64'(a_alu_func3), 64'd4);
        rst = 1'b1;
        #1;
        chk("mid_rst_alu_rs1", 64'(a_alu_rs1),   64'd0);
        chk("mid_rst_alu_rs2", 64'(a_alu_rs2),   64'd0);
        chk("mid_rst_alu_f3",  64'(a_alu_func3), 64'd0);
        chk("mid_rst_valid",   64'(a_rsp_valid), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("mid_no_rsp_1", 64'(a_rsp_valid), 64'd0);
        step();
        chk("mid_no_rsp_2", 64'(a_rsp_valid), 64'd0);
        set_a(1, 7'h00, 3'd0, 32'd100, 32'd1);
        a_req_valid = 2'b11;
        #1;
        chk("mid_post_grant", 64'(a_req_ready), 64'h1);
        step();
        a_req_valid = 2'b00;
        step();
        chk("mid_post_id", 64'(a_rsp_id), 64'd0);
        chk("mid_post_rd", 64'(a_rsp_rd), 64'hFF);
        step();

        // Fairness on 4 requesters: only req2 and req3 valid
        set_b(2, 7'h00, 3'd0, 32'd2, 32'd0);
        set_b(3, 7'h00, 3'd0, 32'd3, 32'd0);
        b_req_valid = 4'b1100;
        #1;
        chk("fair_first_grant", 64'(b_req_ready), 64'h4);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("fair_exec_gap", 64'(b_rsp_valid), 64'd0);
            step();
            chk("fair_rsp_valid", 64'(b_rsp_valid), 64'd1);
            chk("fair_rsp_id",    64'(b_rsp_id),    (i % 2 == 1) ? 64'd3 : 64'd2);
            chk("fair_rsp_rd",    64'(b_rsp_rd),    (i % 2 == 1) ? 64'd3 : 64'd2);
            chk("fair_next_grant", 64'(b_req_ready), (i % 2 == 1) ? 64'h4 : 64'h8);
            step();
        end
        b_req_valid = 4'b0000;
        step();
        step();
        chk("fair_drained", 64'(b_rsp_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
